// File: rtl/ibex_alu_pext_mac_pkg.sv
// Shared types and constants for the Zpn multiply-accumulate engine and its neighbours.
// Holds the operator, FSM state and operator-class enums plus the saturation bounds.
package ibex_pkg_pext;

    typedef enum logic [4:0] {
        ZPN_ADD16,
        ZPN_SUB16,
        ZPN_SMAQA,
        ZPN_MADDR32,
        ZPN_MSUBR32,
        ZPN_KMMAC,
        ZPN_KMMACU,
        ZPN_KMMSB,
        ZPN_KMMSBU
    } zpn_op_e;

    typedef enum logic [2:0] {
        MAC_IDLE,
        MAC_MUL_LL,
        MAC_MUL_LH,
        MAC_MUL_HL,
        MAC_MUL_HH,
        MAC_MUL,
        MAC_ACC,
        MAC_DONE
    } mac_state_e;

    typedef enum logic [1:0] {
        MAC_LOW,
        MAC_HIGH,
        MAC_HIGH_RND
    } mac_class_e;

    localparam logic [63:0] MAC_RND_CONST = 64'h0000_0000_8000_0000;
    localparam logic [31:0] MAC_SAT_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] MAC_SAT_MIN   = 32'h8000_0000;

    function automatic logic is_mac_op(zpn_op_e op);
        return op inside {ZPN_MADDR32, ZPN_MSUBR32, ZPN_KMMAC, ZPN_KMMACU, ZPN_KMMSB, ZPN_KMMSBU};
    endfunction

    // Rounding variants take the upper word of P + 2^31 instead of P.
    function automatic mac_class_e mac_class(zpn_op_e op);
        mac_class_e cls;
        unique case (op)
            ZPN_KMMAC, ZPN_KMMSB:   cls = MAC_HIGH;
            ZPN_KMMACU, ZPN_KMMSBU: cls = MAC_HIGH_RND;
            default:                cls = MAC_LOW;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ibex_alu_pext_mac_if.sv
// Request/response bundle between the Pext decoder/writeback side and the MAC engine.
interface ibex_alu_pext_mac_if;
    import ibex_pkg_pext::*;

    logic        valid;
    logic        ready;
    logic        flush;
    zpn_op_e     zpn_operator;
    logic        signed_ops;
    logic [1:0]  alu_sub;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic        result_valid;
    logic [31:0] result;
    logic        ov;
    logic        busy;

    modport master (
        output valid, flush, zpn_operator, signed_ops, alu_sub, op_a, op_b, op_c,
        input  ready, result_valid, result, ov, busy
    );

    modport slave (
        input  valid, flush, zpn_operator, signed_ops, alu_sub, op_a, op_b, op_c,
        output ready, result_valid, result, ov, busy
    );

endinterface

// File: rtl/ibex_alu_pext_mac_sat.sv
// Combinational 33-bit accumulate (c +/- term) with optional 32-bit signed saturation.
module ibex_alu_pext_mac_sat
    import ibex_pkg_pext::*;
(
    input  logic [31:0] acc_i,
    input  logic [31:0] term_i,
    input  logic        sub_i,
    input  logic        sat_en_i,
    output logic [31:0] result_o,
    output logic        ov_o
);

    logic [32:0] acc_ext;
    logic [32:0] term_ext;
    logic [32:0] sum;
    logic        overflow;

    assign acc_ext  = {acc_i[31], acc_i};
    assign term_ext = {term_i[31], term_i};
    assign sum      = sub_i ? (acc_ext - term_ext) : (acc_ext + term_ext);
    assign overflow = sum[32] ^ sum[31];

    always_comb begin
        result_o = sum[31:0];
        ov_o     = 1'b0;
        if (sat_en_i && overflow) begin
            ov_o     = 1'b1;
            result_o = sum[32] ? MAC_SAT_MIN : MAC_SAT_MAX;
        end
    end

endmodule

// File: rtl/ibex_alu_pext_mac.sv
// Multi-cycle 32x32 MAC for MADDR32/MSUBR32/KMMAC(u)/KMMSB(u).
// Define IBEX_PEXT_MAC_FAST_EN for a single-cycle 33x33 multiplier instead of four 17x17 steps.
module ibex_alu_pext_mac
    import ibex_pkg_pext::*;
#(
    parameter bit EarlyLowExit = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    ibex_alu_pext_mac_if.slave        mac
);

    mac_state_e  state_q, state_d;
    logic [31:0] a_q, b_q, c_q;
    mac_class_e  class_q;
    logic        sub_q;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q;
    logic        ov_q;

    logic        ready;
    logic        accept;
    logic [63:0] mul_acc;
    logic [63:0] rnd_full;
    logic [31:0] term;
    logic [31:0] sat_result;
    logic        sat_ov;

    assign ready  = (state_q == MAC_IDLE) || (state_q == MAC_DONE);
    assign accept = mac.valid && ready && !mac.flush;

`ifdef IBEX_PEXT_MAC_FAST_EN
    localparam mac_state_e FirstMul = MAC_MUL;

    logic signed [32:0] fast_a, fast_b;
    logic signed [63:0] fast_prod;

    assign fast_a    = {a_q[31], a_q};
    assign fast_b    = {b_q[31], b_q};
    assign fast_prod = 64'(fast_a) * 64'(fast_b);
    assign mul_acc   = fast_prod;
`else
    localparam mac_state_e FirstMul = MAC_MUL_LL;

    logic signed [16:0] mul_a, mul_b;
    logic signed [33:0] pp;
    logic [63:0]        pp_ext;
    logic [63:0]        pp_shifted;

    // Low halves zero-extended, high halves sign-extended, so the four products sum to a*b.
    always_comb begin
        mul_a = {1'b0, a_q[15:0]};
        mul_b = {1'b0, b_q[15:0]};
        unique case (state_q)
            MAC_MUL_LH: mul_b = {b_q[31], b_q[31:16]};
            MAC_MUL_HL: mul_a = {a_q[31], a_q[31:16]};
            MAC_MUL_HH: begin
                mul_a = {a_q[31], a_q[31:16]};
                mul_b = {b_q[31], b_q[31:16]};
            end
            default: ;
        endcase
    end

    assign pp     = mul_a * mul_b;
    assign pp_ext = {{30{pp[33]}}, pp};

    always_comb begin
        pp_shifted = '0;
        unique case (state_q)
            MAC_MUL_LL:             pp_shifted = pp_ext;
            MAC_MUL_LH, MAC_MUL_HL: pp_shifted = pp_ext << 16;
            MAC_MUL_HH:             pp_shifted = pp_ext << 32;
            default: ;
        endcase
    end

    assign mul_acc = acc_q + pp_shifted;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        unique case (state_q)
            MAC_IDLE, MAC_DONE: state_d = MAC_IDLE;
            MAC_MUL_LL: begin
                state_d = MAC_MUL_LH;
                acc_d   = mul_acc;
            end
            MAC_MUL_LH: begin
                state_d = MAC_MUL_HL;
                acc_d   = mul_acc;
            end
            MAC_MUL_HL: begin
                // HH only touches bits 63:32, which low-word ops never look at.
                state_d = (EarlyLowExit && class_q == MAC_LOW) ? MAC_ACC : MAC_MUL_HH;
                acc_d   = mul_acc;
            end
            MAC_MUL_HH, MAC_MUL: begin
                state_d = MAC_ACC;
                acc_d   = mul_acc;
            end
            MAC_ACC: state_d = MAC_DONE;
            default: state_d = MAC_IDLE;
        endcase
        if (accept) begin
            state_d = FirstMul;
            acc_d   = '0;
        end
        if (mac.flush) begin
            state_d = MAC_IDLE;
        end
    end

    assign rnd_full = acc_q + ((class_q == MAC_HIGH_RND) ? MAC_RND_CONST : 64'h0);
    assign term     = (class_q == MAC_LOW) ? rnd_full[31:0] : rnd_full[63:32];

    ibex_alu_pext_mac_sat u_sat (
        .acc_i    (c_q),
        .term_i   (term),
        .sub_i    (sub_q),
        .sat_en_i (class_q != MAC_LOW),
        .result_o (sat_result),
        .ov_o     (sat_ov)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MAC_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            class_q  <= MAC_LOW;
            sub_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (accept) begin
                a_q     <= mac.op_a;
                b_q     <= mac.op_b;
                c_q     <= mac.op_c;
                class_q <= mac_class(mac.zpn_operator);
                sub_q   <= (mac.alu_sub == 2'b11);
            end
            if (state_q == MAC_ACC && !mac.flush) begin
                result_q <= sat_result;
                ov_q     <= sat_ov;
            end
        end
    end

    assign mac.ready        = ready;
    assign mac.result_valid = (state_q == MAC_DONE) && !mac.flush;
    assign mac.result       = result_q;
    assign mac.ov           = ov_q;
    assign mac.busy         = !ready;

    MacOpKnown: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (is_mac_op(mac.zpn_operator) && mac.signed_ops));

endmodule

// File: tb/tb_ibex_alu_pext_mac.sv
// Scoreboard bench for ibex_alu_pext_mac: directed cases, random MAC traffic, flush and reset.
module tb_ibex_alu_pext_mac;
    import ibex_pkg_pext::*;

`ifdef IBEX_PEXT_MAC_FAST_EN
    localparam int LatHigh = 3;
    localparam int LatLow  = 3;
`else
    localparam int LatHigh = 6;
    localparam int LatLow  = 5;
`endif

    typedef struct {
        logic [31:0] res;
        logic        ov;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    logic [31:0] lastResult = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_alu_pext_mac_if macIf ();

    ibex_alu_pext_mac #(.EarlyLowExit(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .mac    (macIf.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: exact 64-bit signed product, then the instruction's word/round/saturate rules.
    function automatic void model(input zpn_op_e op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, output logic [31:0] res, output logic ov);
        longint p;
        longint s;
        longint hi;
        logic [31:0] lo;
        bit isSub;
        p     = longint'($signed(a)) * longint'($signed(b));
        isSub = op inside {ZPN_MSUBR32, ZPN_KMMSB, ZPN_KMMSBU};
        ov    = 1'b0;
        if (op inside {ZPN_MADDR32, ZPN_MSUBR32}) begin
            lo  = p[31:0];
            res = isSub ? (c - lo) : (c + lo);
        end else begin
            if (op inside {ZPN_KMMACU, ZPN_KMMSBU}) p = p + 64'sh8000_0000;
            hi = p >>> 32;
            s  = isSub ? (longint'($signed(c)) - hi) : (longint'($signed(c)) + hi);
            if (s > 64'sh7FFF_FFFF) begin
                res = 32'h7FFF_FFFF;
                ov  = 1'b1;
            end else if (s < -64'sh8000_0000) begin
                res = 32'h8000_0000;
                ov  = 1'b1;
            end else begin
                res = s[31:0];
            end
        end
    endfunction

    // Caller sits just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input zpn_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input bit expectResult);
        exp_t e;
        bit accepted = 0;
        macIf.valid        = 1'b1;
        macIf.zpn_operator = op;
        macIf.signed_ops   = 1'b1;
        macIf.alu_sub      = (op inside {ZPN_MSUBR32, ZPN_KMMSB, ZPN_KMMSBU}) ? 2'b11 : 2'b00;
        macIf.op_a         = a;
        macIf.op_b         = b;
        macIf.op_c         = c;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (macIf.ready) begin
                accepted = 1;
                if (expectResult) begin
                    model(op, a, b, c, e.res, e.ov);
                    e.cyc = cyc + ((op inside {ZPN_MADDR32, ZPN_MSUBR32}) ? LatLow : LatHigh);
                    expQ.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
        macIf.valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("drainPending", expQ.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rstN) begin
            lastResult = '0;
        end else if (macIf.result_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedValid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", macIf.result, e.res);
                checkOutput("ov", {31'd0, macIf.ov}, {31'd0, e.ov});
                checkOutput("latency", cyc, e.cyc);
            end
            lastResult = macIf.result;
        end else begin
            checkOutput("resultHeld", macIf.result, lastResult);
        end
    end

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        zpn_op_e ops[6] = '{ZPN_MADDR32, ZPN_MSUBR32, ZPN_KMMAC, ZPN_KMMACU, ZPN_KMMSB, ZPN_KMMSBU};
        macIf.valid        = 1'b0;
        macIf.flush        = 1'b0;
        macIf.zpn_operator = ZPN_MADDR32;
        macIf.signed_ops   = 1'b1;
        macIf.alu_sub      = 2'b00;
        macIf.op_a         = '0;
        macIf.op_b         = '0;
        macIf.op_c         = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstValid", {31'd0, macIf.result_valid}, 32'd0);
        checkOutput("rstResult", macIf.result, 32'd0);
        checkOutput("rstOv", {31'd0, macIf.ov}, 32'd0);
        checkOutput("rstBusy", {31'd0, macIf.busy}, 32'd0);
        checkOutput("rstReady", {31'd0, macIf.ready}, 32'd1);
        @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(ZPN_MADDR32, 32'd3, 32'd5, 32'd10, 1);
        waitDrain();
        applyStimulus(ZPN_MSUBR32, 32'hFFFF_FFFF, 32'd2, 32'd0, 1);
        applyStimulus(ZPN_KMMAC, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFF0, 1);
        applyStimulus(ZPN_KMMACU, 32'h0001_0000, 32'h0000_8000, 32'd0, 1);
        applyStimulus(ZPN_KMMAC, 32'h0001_0000, 32'h0000_8000, 32'd0, 1);
        // Second op is accepted in the first op's DONE cycle.
        applyStimulus(ZPN_KMMSB, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1);
        applyStimulus(ZPN_KMMSBU, 32'h1234_5678, 32'h8765_4321, 32'h0000_0042, 1);
        waitDrain();

        for (int n = 0; n < 60; n++) begin
            applyStimulus(ops[$urandom_range(0, 5)], pickOperand(), pickOperand(), pickOperand(), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        waitDrain();

        applyStimulus(ZPN_KMMAC, 32'h0000_1234, 32'h0003_0000, 32'h1111_1111, 0);
        repeat (2) @(posedge clk);
        #1 macIf.flush = 1'b1;
        @(posedge clk);
        #1 macIf.flush = 1'b0;
        checkOutput("flushReady", {31'd0, macIf.ready}, 32'd1);
        checkOutput("flushBusy", {31'd0, macIf.busy}, 32'd0);
        checkOutput("flushResult", macIf.result, lastResult);
        repeat (8) @(posedge clk);
        #1;

        macIf.valid = 1'b1;
        macIf.flush = 1'b1;
        @(posedge clk);
        #1;
        macIf.valid = 1'b0;
        macIf.flush = 1'b0;
        checkOutput("flushWinsBusy", {31'd0, macIf.busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1;

        applyStimulus(ZPN_MADDR32, 32'd7, 32'd9, 32'd1, 1);
        waitDrain();
        applyStimulus(ZPN_KMMSB, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0);
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midRstValid", {31'd0, macIf.result_valid}, 32'd0);
        checkOutput("midRstResult", macIf.result, 32'd0);
        checkOutput("midRstOv", {31'd0, macIf.ov}, 32'd0);
        checkOutput("midRstBusy", {31'd0, macIf.busy}, 32'd0);
        checkOutput("midRstReady", {31'd0, macIf.ready}, 32'd1);
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        applyStimulus(ZPN_KMMACU, 32'hFFFF_0000, 32'h0001_8000, 32'h0000_0005, 1);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
